apb4_reg_slave: RTL and testbench

- APB4 completer (responder) at the far end of the bridge's APB4 master port: a bank of NREGS DW-bit read/write registers.
- Adds a fixed number of wait states and byte-strobe writes.
- Signals PSLVERR for out-of-range or misaligned accesses.
- Serves as the bridge's standard APB target in both single-clock and multi-clock configurations.

---
 rtl/apb4_reg_slave.sv | 163 ++++++++++++++++
 tb/tb_apb4_reg_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb4_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb4_reg_slave
// Brief    : APB4 completer with a bank of NREGS read/write registers,
//            fixed wait states, byte-strobe writes and PSLVERR on
//            out-of-range or misaligned accesses.
// Options  : define APB4_SLV_PROT_CHECK_EN to reject unprivileged writes
//            (PPROT[0]==0) with PSLVERR; otherwise PPROT is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_reg_slave #(
  parameter int          DW          = 32,
  parameter int          NREGS       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSELx,
  input  logic [31:0]         PADDR,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [2:0]          PPROT,
  input  logic [DW-1:0]       PWDATA,
  input  logic [DW/8-1:0]     PSTRB,
  output logic                PREADY,
  output logic [DW-1:0]       PRDATA,
  output logic                PSLVERR,
  output logic [NREGS*DW-1:0] regs_q
);

  localparam int          c_IW        = $clog2(NREGS);
  localparam logic [31:0] c_ADDR_MASK = ~(32'(NREGS * 4) - 32'd1);
  localparam logic [3:0]  c_WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [c_IW-1:0] r_idx;
  logic            r_err;
  logic            r_write;
  logic            r_pready;
  logic [DW-1:0]   r_prdata;
  logic            r_pslverr;
  logic [DW-1:0]   r_regs [NREGS];

  logic [c_IW-1:0] w_idx;
  logic            w_hit;
  logic            w_err;
  logic [DW-1:0]   w_rd_setup;
  logic [DW-1:0]   w_rd_latched;
  logic            w_unused_ok;

  // Address decode of the bus as presented in the setup cycle
  assign w_idx = PADDR[2 +: c_IW];
  assign w_hit = (PADDR & c_ADDR_MASK) == BASE_ADDR;
`ifdef APB4_SLV_PROT_CHECK_EN
  assign w_err = !w_hit || (PADDR[1:0] != 2'b00) || (PWRITE && !PPROT[0]);
`else
  assign w_err = !w_hit || (PADDR[1:0] != 2'b00);
`endif
  // PPROT bits that do not feed the error term are deliberately dropped
  assign w_unused_ok = ^PPROT;

  // Read data: zero for writes and errored accesses. The setup-time variant
  // serves the zero-wait-state path, the latched one serves the WAIT path.
  assign w_rd_setup   = (!PWRITE  && !w_err) ? r_regs[w_idx] : '0;
  assign w_rd_latched = (!r_write && !r_err) ? r_regs[r_idx] : '0;

  // Transfer FSM, registered bus responses and register bank
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          // Only a genuine setup phase starts a transfer; a stray PENABLE is ignored
          if (PSELx && !PENABLE) begin
            r_idx   <= w_idx;
            r_err   <= w_err;
            r_write <= PWRITE;
            if (WAIT_STATES == 0) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rd_setup;
            end else begin
              r_cnt   <= c_WS;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSELx) begin
            // Master dropped the transfer: nothing is written
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
          end else if (r_cnt == 4'd1) begin
            r_cnt     <= 4'd0;
            r_state   <= S_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= w_rd_latched;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          // Write commits on the completion edge only, lane by lane
          if (PSELx && PENABLE && r_write && !r_err) begin
            for (int b = 0; b < DW / 8; b++) begin
              if (PSTRB[b]) begin
                r_regs[r_idx][8*b +: 8] <= PWDATA[8*b +: 8];
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
      assign regs_q[gi*DW +: DW] = r_regs[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb4_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb4_reg_slave
// Brief    : Scoreboard bench for apb4_reg_slave. Instance 0 uses two wait
//            states, instance 1 uses none. Honours APB4_SLV_PROT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_reg_slave;

`ifdef APB4_SLV_PROT_CHECK_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        psel, penable, pwrite, pready, pslverr;
  logic [1:0][31:0]  paddr, pwdata, prdata;
  logic [1:0][2:0]   pprot;
  logic [1:0][3:0]   pstrb;
  logic [1:0][511:0] regs_q;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [511:0] exp_bank;

  apb4_reg_slave #(.WAIT_STATES(2)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[0]), .PADDR(paddr[0]),
    .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PPROT(pprot[0]),
    .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PREADY(pready[0]),
    .PRDATA(prdata[0]), .PSLVERR(pslverr[0]), .regs_q(regs_q[0])
  );

  apb4_reg_slave #(.WAIT_STATES(0)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[1]), .PADDR(paddr[1]),
    .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PPROT(pprot[1]),
    .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PREADY(pready[1]),
    .PRDATA(prdata[1]), .PSLVERR(pslverr[1]), .regs_q(regs_q[1])
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every PREADY pulse must match the oldest expected response
  task automatic mon_one(input int d);
    exp_t e;
    if (pready[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pready dut%0d: got 1 expected 0", d);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("prdata dut%0d", d), prdata[d], e.rd);
        check($sformatf("pslverr dut%0d", d), pslverr[d], e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0);
    mon_one(1);
  end

  // One full transfer; called at posedge+1, returns just after completion edge
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input logic [31:0] exp_rd, input logic exp_err);
    int k;
    exp_t e;
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w;
    pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    e.rd = exp_rd; e.err = exp_err;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    k = 1;
    while (!pready[d] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("latency dut%0d addr %h", d, a), k, (d == 0) ? 3 : 1);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    pprot = '0; pstrb = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_outputs dut0", {pready[0], pslverr[0], prdata[0]}, 0);
    check("rst_outputs dut1", {pready[1], pslverr[1], prdata[1]}, 0);
    check("rst_regs dut0", regs_q[0], 0);
    check("rst_regs dut1", regs_q[1], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read after reset, two wait states
    xfer(0, 32'h4000_0008, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0000_0000, 1'b0);

    // Full write then strobed partial write, then read back
    xfer(0, 32'h4000_0004, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b001, 32'h0, 1'b0);
    check("t2_full_write", regs_q[0][63:32], 32'hDEAD_BEEF);
    xfer(0, 32'h4000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0101, 3'b001, 32'h0, 1'b0);
    xfer(0, 32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'b001, 32'hDEA5_BEA5, 1'b0);
    check("t2_regs_q", regs_q[0][63:32], 32'hDEA5_BEA5);

    // Error responses: out of range, below base, misaligned
    xfer(0, 32'h4000_0040, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1);
    xfer(0, 32'h4000_0044, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1);
    xfer(0, 32'h3FFF_FFFC, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1);
    xfer(0, 32'h4000_0002, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1);
    xfer(0, 32'h4000_0045, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1);
    exp_bank = '0;
    exp_bank[63:32] = 32'hDEA5_BEA5;
    check("t3_regs_unchanged", regs_q[0], exp_bank);

    // Zero wait states, back-to-back writes
    xfer(1, 32'h4000_0000, 1'b1, 32'h1111_1111, 4'hF, 3'b001, 32'h0, 1'b0);
    check("t4_reg0", regs_q[1][31:0], 32'h1111_1111);
    xfer(1, 32'h4000_0004, 1'b1, 32'h2222_2222, 4'hF, 3'b001, 32'h0, 1'b0);
    check("t4_reg1", regs_q[1][63:32], 32'h2222_2222);
    xfer(1, 32'h4000_0008, 1'b1, 32'h3333_3333, 4'hF, 3'b001, 32'h0, 1'b0);
    check("t4_reg2", regs_q[1][95:64], 32'h3333_3333);
    // Empty strobe is a no-op
    xfer(1, 32'h4000_0008, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'b001, 32'h0, 1'b0);
    check("t4_strb0_noop", regs_q[1][95:64], 32'h3333_3333);
    // Read immediately after the writes
    xfer(1, 32'h4000_0004, 1'b0, 32'h0, 4'hF, 3'b001, 32'h2222_2222, 1'b0);
    // PENABLE high without a setup phase is ignored
    psel[1] = 1'b1; penable[1] = 1'b1; paddr[1] = 32'h4000_0000; pwrite[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_setup_pready", pready[1], 1'b0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;

    // Privilege check on writes to idx 5
    xfer(1, 32'h4000_0014, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, PROT_ON);
    check("t6_unpriv_write", regs_q[1][191:160], PROT_ON ? 32'h0 : 32'hCAFE_F00D);
    xfer(1, 32'h4000_0014, 1'b1, 32'h0BAD_C0DE, 4'hF, 3'b001, 32'h0, 1'b0);
    check("t6_priv_write", regs_q[1][191:160], 32'h0BAD_C0DE);
    // Unprivileged read is never rejected
    xfer(1, 32'h4000_0014, 1'b0, 32'h0, 4'hF, 3'b000, 32'h0BAD_C0DE, 1'b0);

    // Abort in the first WAIT cycle of a write to idx 3
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h4000_000C; pwrite[0] = 1'b1;
    pwdata[0] = 32'h1234_5678; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    penable[0] = 1'b0;
    check("t5_abort_pready", pready[0], 1'b0);
    check("t5_abort_reg3", regs_q[0][127:96], 32'h0);
    // After the abort a normal read still works
    xfer(0, 32'h4000_0004, 1'b0, 32'h0, 4'hF, 3'b001, 32'hDEA5_BEA5, 1'b0);

    // Reset while dut0 waits and dut1 is presenting its response
    psel = 2'b11; penable = 2'b00; pwrite = 2'b00;
    paddr[0] = 32'h4000_0004; paddr[1] = 32'h4000_0004;
    @(posedge clk); #1;
    penable = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs dut0", {pready[0], pslverr[0], prdata[0]}, 0);
    check("t5_rst_outputs dut1", {pready[1], pslverr[1], prdata[1]}, 0);
    check("t5_rst_regs dut0", regs_q[0], 0);
    check("t5_rst_regs dut1", regs_q[1], 0);
    psel = 2'b00; penable = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h4000_0004, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0);
    xfer(1, 32'h4000_0014, 1'b0, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
